sort_method_responder: RTL and testbench

- Hardware responder for the req/busy/return method-call handshake that our bench tops use as initiators.
- Holds a DEPTH-entry register array loaded through a simple host port.
- Exposes two methods: `sort`, an in-place ascending unsigned bubble sort with early exit, and `check`, which returns 1 if the array is non-decreasing.
- Sits as the callee under a bench top or a Synthesijer-generated caller.

---
 rtl/sort_method_responder.sv | 132 +++++++++++++
 tb/tb_sort_method_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_method_responder.sv
// sort_method_responder: callee for the req/busy/return method handshake.
// Holds a DEPTH-entry array loaded through a host port and offers two methods:
//   sort  - in-place ascending unsigned bubble sort with early exit
//   check - returns 1 when the array is non-decreasing (always a full scan)
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   data_addr/data_din/data_we      host write port (honoured in IDLE only)
//   data_dout                       registered read of array[data_addr]
//   sort_req / sort_busy            sort method handshake, swap_count result
//   check_req / check_busy          check method handshake, check_return result
module sort_method_responder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_din,
  input  logic              data_we,
  output logic [DATA_W-1:0] data_dout,
  input  logic              sort_req,
  output logic              sort_busy,
  input  logic              check_req,
  output logic              check_busy,
  output logic              check_return,
  output logic [15:0]       swap_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CHECK_END = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, SORT, CHECK, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last;
  logic              swapped;
  logic              ok;

  logic [ADDR_W-1:0] idx_next_c;
  logic              gt_c;

  // Shared comparator for both methods: array[idx] > array[idx+1].
  always_comb begin
    idx_next_c = idx + ONE;
    gt_c       = mem[idx] > mem[idx_next_c];
  end

  // Array storage: never reset, written by the host in IDLE or by sort swaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == IDLE && data_we) begin
        mem[data_addr] <= data_din;
      end else if (state == SORT && gt_c) begin
        mem[idx]        <= mem[idx_next_c];
        mem[idx_next_c] <= mem[idx];
      end
    end
  end

  // Method-call FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sort_busy    <= 1'b0;
      check_busy   <= 1'b0;
      check_return <= 1'b0;
      swap_count   <= 16'd0;
      data_dout    <= '0;
      idx          <= '0;
      last         <= LAST_IDX;
      swapped      <= 1'b0;
      ok           <= 1'b1;
    end else begin
      data_dout <= mem[data_addr];
      case (state)
        IDLE: begin
          if (sort_req) begin
            state      <= SORT;
            sort_busy  <= 1'b1;
            idx        <= '0;
            last       <= LAST_IDX;
            swapped    <= 1'b0;
            swap_count <= 16'd0;
          end else if (check_req) begin
            state      <= CHECK;
            check_busy <= 1'b1;
            idx        <= '0;
            ok         <= 1'b1;
          end
        end
        SORT: begin
          if (gt_c) begin
            swapped <= 1'b1;
            if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
          end
          if (idx == last - ONE) begin
            // End of pass: stop when this pass (including this compare) made no swap.
            if (!(swapped || gt_c) || last == ONE) begin
              state <= DONE;
            end else begin
              last    <= last - ONE;
              idx     <= '0;
              swapped <= 1'b0;
            end
          end else begin
            idx <= idx_next_c;
          end
        end
        CHECK: begin
          ok <= ok & ~gt_c;
          if (idx == CHECK_END) begin
            state        <= DONE;
            check_return <= ok & ~gt_c;
          end else begin
            idx <= idx_next_c;
          end
        end
        DONE: begin
          state      <= IDLE;
          sort_busy  <= 1'b0;
          check_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_method_responder.sv
// Testbench for sort_method_responder: randomized and directed calls checked
// against a reference model (inversion counts, pass counts, software sort).
module tb_sort_method_responder;

  localparam int DEPTH = 16;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  data_addr = '0;
  logic [31:0] data_din = '0;
  logic        data_we = 1'b0;
  logic [31:0] data_dout;
  logic        sort_req = 1'b0;
  logic        sort_busy;
  logic        check_req = 1'b0;
  logic        check_busy;
  logic        check_return;
  logic [15:0] swap_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_arr [DEPTH];
  logic [31:0] rd [DEPTH];

  sort_method_responder #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data_din(data_din),
    .data_we(data_we), .data_dout(data_dout), .sort_req(sort_req),
    .sort_busy(sort_busy), .check_req(check_req), .check_busy(check_busy),
    .check_return(check_return), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int inversions();
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (model[i] > model[j]) n++;
    return n;
  endfunction

  // Bubble sort moves an element left by at most one slot per pass, so the
  // number of swapping passes equals the largest count of strictly greater
  // elements in front of any element; one extra clean pass detects the end.
  function automatic int sort_busy_cycles();
    int maxleft = 0;
    int passes;
    int cmp = 0;
    for (int j = 0; j < DEPTH; j++) begin
      int c = 0;
      for (int i = 0; i < j; i++) if (model[i] > model[j]) c++;
      if (c > maxleft) maxleft = c;
    end
    passes = maxleft + 1;
    if (passes > DEPTH - 1) passes = DEPTH - 1;
    for (int p = 1; p <= passes; p++) cmp += DEPTH - p;
    return cmp + 1;
  endfunction

  function automatic void make_sorted();
    logic [31:0] t;
    for (int i = 0; i < DEPTH; i++) exp_arr[i] = model[i];
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (exp_arr[j] < exp_arr[i]) begin
          t = exp_arr[i]; exp_arr[i] = exp_arr[j]; exp_arr[j] = t;
        end
  endfunction

  function automatic logic is_sorted();
    for (int i = 0; i + 1 < DEPTH; i++) if (model[i] > model[i+1]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic write_model();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      data_we = 1'b1; data_addr = 4'(i); data_din = model[i];
    end
    @(negedge clk);
    data_we = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      data_addr = 4'(i);
      @(negedge clk);
      rd[i] = data_dout;
    end
  endtask

  // Pulses the request and counts cycles busy is observed high (bounded).
  task automatic run_call(input bit is_sort, output int cycles);
    @(negedge clk);
    if (is_sort) sort_req = 1'b1; else check_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0; check_req = 1'b0;
    cycles = 0;
    while ((is_sort ? sort_busy : check_busy) && cycles < LIMIT) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sort_busy, check_busy, check_return} !== 3'b000 || swap_count !== 16'd0 || data_dout !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b%b ret=%b swaps=%0d dout=%h required all zero",
               sort_busy, check_busy, check_return, swap_count, data_dout);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reverse_sort();
    int cyc;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(DEPTH - 1 - i);
    write_model();
    make_sorted();
    run_call(1'b1, cyc);
    checks++;
    if (cyc !== 121 || cyc !== sort_busy_cycles()) begin
      failures++; $display("FAIL reverse_busy: got %0d required 121", cyc);
    end
    checks++;
    if (swap_count !== 16'(inversions())) begin
      failures++; $display("FAIL reverse_swaps: got %0d required %0d", swap_count, inversions());
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd[i] !== exp_arr[i]) begin
        failures++; $display("FAIL reverse_data[%0d]: got %0d required %0d", i, rd[i], exp_arr[i]);
      end
    end
  endtask

  task automatic test_presorted();
    int cyc;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    write_model();
    run_call(1'b1, cyc);
    checks++;
    if (cyc !== 16) begin failures++; $display("FAIL presorted_busy: got %0d required 16", cyc); end
    checks++;
    if (swap_count !== 16'd0) begin failures++; $display("FAIL presorted_swaps: got %0d required 0", swap_count); end
    run_call(1'b0, cyc);
    checks++;
    if (cyc !== 16) begin failures++; $display("FAIL check_busy_len: got %0d required 16", cyc); end
    checks++;
    if (check_return !== 1'b1) begin failures++; $display("FAIL presorted_check: got %b required 1", check_return); end
  endtask

  task automatic test_one_low();
    int cyc;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd7;
    model[3] = 32'd2;
    write_model();
    make_sorted();
    run_call(1'b0, cyc);
    checks++;
    if (check_return !== is_sorted() || cyc !== 16) begin
      failures++; $display("FAIL onelow_check: got ret=%b cyc=%0d required ret=0 cyc=16", check_return, cyc);
    end
    run_call(1'b1, cyc);
    checks++;
    if (swap_count !== 16'd3 || cyc !== sort_busy_cycles()) begin
      failures++; $display("FAIL onelow_sort: got swaps=%0d cyc=%0d required 3/%0d", swap_count, cyc, sort_busy_cycles());
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd[i] !== exp_arr[i]) begin
        failures++; $display("FAIL onelow_data[%0d]: got %0d required %0d", i, rd[i], exp_arr[i]);
      end
    end
    run_call(1'b0, cyc);
    checks++;
    if (check_return !== 1'b1) begin failures++; $display("FAIL onelow_recheck: got %b required 1", check_return); end
  endtask

  task automatic test_priority();
    int n = 0;
    @(negedge clk);
    sort_req = 1'b1; check_req = 1'b1;
    @(negedge clk);
    checks++;
    if (sort_busy !== 1'b1 || check_busy !== 1'b0) begin
      failures++; $display("FAIL prio_first: got sort=%b check=%b required 1/0", sort_busy, check_busy);
    end
    while (sort_busy && n < LIMIT) begin n++; @(negedge clk); end
    checks++;
    if (sort_busy !== 1'b0 || check_busy !== 1'b0) begin
      failures++; $display("FAIL prio_gap: got sort=%b check=%b required 0/0", sort_busy, check_busy);
    end
    @(negedge clk);
    checks++;
    if (sort_busy !== 1'b1 || check_busy !== 1'b0) begin
      failures++; $display("FAIL prio_relaunch: got sort=%b check=%b required 1/0", sort_busy, check_busy);
    end
    sort_req = 1'b0;
    n = 0;
    while (sort_busy && n < LIMIT) begin n++; @(negedge clk); end
    @(negedge clk);
    checks++;
    if (check_busy !== 1'b1 || sort_busy !== 1'b0) begin
      failures++; $display("FAIL prio_check_runs: got sort=%b check=%b required 0/1", sort_busy, check_busy);
    end
    check_req = 1'b0;
    n = 0;
    while (check_busy && n < LIMIT) begin n++; @(negedge clk); end
  endtask

  task automatic test_write_ignored();
    int cyc;
    for (int i = 0; i < DEPTH; i++) model[i] = $urandom;
    write_model();
    make_sorted();
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0;
    data_we = 1'b1; data_addr = 4'd0; data_din = 32'hFFFF_FFFF;
    repeat (5) @(negedge clk);
    data_we = 1'b0;
    cyc = 0;
    while (sort_busy && cyc < LIMIT) begin cyc++; @(negedge clk); end
    checks++;
    if (swap_count !== 16'(inversions())) begin
      failures++; $display("FAIL wign_swaps: got %0d required %0d", swap_count, inversions());
    end
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd[i] !== exp_arr[i]) begin
        failures++; $display("FAIL wign_data[%0d]: got %h required %h", i, rd[i], exp_arr[i]);
      end
    end
    run_call(1'b0, cyc);
    checks++;
    if (check_return !== 1'b1) begin failures++; $display("FAIL wign_check: got %b required 1", check_return); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(DEPTH - 1 - i);
    write_model();
    make_sorted();
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (sort_busy !== 1'b0 || swap_count !== 16'd0 || check_return !== 1'b0) begin
      failures++; $display("FAIL midreset_state: got busy=%b swaps=%0d ret=%b required 0/0/0",
                           sort_busy, swap_count, check_return);
    end
    reset = 1'b1;
    run_call(1'b1, cyc);
    read_all();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd[i] !== exp_arr[i]) begin
        failures++; $display("FAIL midreset_data[%0d]: got %0d required %0d", i, rd[i], exp_arr[i]);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++)
        model[i] = (it % 2 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      write_model();
      make_sorted();
      run_call(1'b0, cyc);
      checks++;
      if (check_return !== is_sorted()) begin
        failures++; $display("FAIL rand%0d_precheck: got %b required %b", it, check_return, is_sorted());
      end
      run_call(1'b1, cyc);
      checks++;
      if (cyc !== sort_busy_cycles()) begin
        failures++; $display("FAIL rand%0d_busy: got %0d required %0d", it, cyc, sort_busy_cycles());
      end
      checks++;
      if (swap_count !== 16'(inversions())) begin
        failures++; $display("FAIL rand%0d_swaps: got %0d required %0d", it, swap_count, inversions());
      end
      read_all();
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (rd[i] !== exp_arr[i]) begin
          failures++; $display("FAIL rand%0d_data[%0d]: got %h required %h", it, i, rd[i], exp_arr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reverse_sort();
    test_presorted();
    test_one_low();
    test_priority();
    test_write_ignored();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
